cache_controller: RTL and testbench

//  2-way set-associative, write-through, no-write-allocate data cache between the MEM stage and
//  the SRAM controller. Read hits complete in the request cycle; misses and all writes go to SRAM.

---
 rtl/cache_controller_if.sv | 26 ++
 rtl/cache_controller.sv | 147 ++++++++++++++
 tb/tb_cache_controller.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/cache_controller_if.sv
// Bundles the pipeline-side request bus and the SRAM-controller bus of the data cache.
// The cache uses the slave modport; the surrounding pipeline/SRAM model uses master.
interface cache_controller_if;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        sram_rd_en;
  logic        sram_wr_en;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_ready;

  modport slave (
    input  MEM_R_EN, MEM_W_EN, address, wdata, sram_rdata, sram_ready,
    output rdata, ready, sram_rd_en, sram_wr_en, sram_addr, sram_wdata
  );

  modport master (
    output MEM_R_EN, MEM_W_EN, address, wdata, sram_rdata, sram_ready,
    input  rdata, ready, sram_rd_en, sram_wr_en, sram_addr, sram_wdata
  );
endinterface

// File: rtl/cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate data cache in front of the SRAM
// controller. Read hits return in the request cycle; misses and writes wait for sram_ready.
module cache_controller #(
  parameter int BASE_ADDR = 1024,
  parameter int SET_BITS  = 6,
  parameter int TAG_BITS  = 11
) (
  input  logic               clk,
  input  logic               rst,
  cache_controller_if.slave  bus
);

  localparam int SETS      = 1 << SET_BITS;
  localparam int LINE_BITS = SET_BITS + TAG_BITS;
  localparam logic [31:0] BASE = 32'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;

  state_t state, next_state;

  logic [SETS-1:0]     valid [2];
  logic [SETS-1:0]     lru;
  logic [TAG_BITS-1:0] tag_mem  [2][SETS];
  logic [31:0]         data_mem [2][SETS];

  logic [LINE_BITS-1:0] line_addr;
  logic [SET_BITS-1:0]  index;
  logic [TAG_BITS-1:0]  tag;
  logic                 hit0, hit1, hit, hit_way;
  logic [31:0]          hit_data;

  logic fill_en, touch_en, write_hit_en;

  // BASE is word aligned, so subtracting only the word-address bits gives the same index/tag.
  assign line_addr = bus.address[2 +: LINE_BITS] - BASE[2 +: LINE_BITS];
  assign index     = line_addr[SET_BITS-1:0];
  assign tag       = line_addr[LINE_BITS-1:SET_BITS];

  assign hit0     = valid[0][index] && (tag_mem[0][index] == tag);
  assign hit1     = valid[1][index] && (tag_mem[1][index] == tag);
  assign hit      = hit0 || hit1;
  assign hit_way  = hit1;
  assign hit_data = hit1 ? data_mem[1][index] : data_mem[0][index];

  assign bus.sram_addr  = bus.address;
  assign bus.sram_wdata = bus.wdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state     = state;
    bus.ready      = 1'b1;
    bus.rdata      = 32'd0;
    bus.sram_rd_en = 1'b0;
    bus.sram_wr_en = 1'b0;
    fill_en        = 1'b0;
    touch_en       = 1'b0;
    write_hit_en   = 1'b0;

    if (!rst) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          // A simultaneous load and store is serviced as a store.
          if (bus.MEM_W_EN) begin
            bus.ready      = 1'b0;
            bus.sram_wr_en = 1'b1;
            write_hit_en   = hit;
            next_state     = WR_THRU;
          end else if (bus.MEM_R_EN) begin
            if (hit) begin
              bus.rdata = hit_data;
              touch_en  = 1'b1;
            end else begin
              bus.ready      = 1'b0;
              bus.sram_rd_en = 1'b1;
              next_state     = RD_MISS;
            end
          end
        end

        RD_MISS: begin
          if (!bus.MEM_R_EN && !bus.MEM_W_EN) begin
            next_state = IDLE;
          end else begin
            bus.sram_rd_en = 1'b1;
            if (bus.sram_ready) begin
              bus.rdata  = bus.sram_rdata;
              fill_en    = 1'b1;
              next_state = IDLE;
            end else begin
              bus.ready = 1'b0;
            end
          end
        end

        WR_THRU: begin
          if (!bus.MEM_R_EN && !bus.MEM_W_EN) begin
            next_state = IDLE;
          end else begin
            bus.sram_wr_en = 1'b1;
            if (bus.sram_ready) begin
              next_state = IDLE;
            end else begin
              bus.ready = 1'b0;
            end
          end
        end

        default: next_state = IDLE;
      endcase
    end
  end

  // Valid and LRU bits are the only cache state that reset must clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid[0] <= '0;
      valid[1] <= '0;
      lru      <= '0;
    end else if (fill_en) begin
      valid[lru[index]][index] <= 1'b1;
      lru[index]               <= ~lru[index];
    end else if (touch_en || write_hit_en) begin
      lru[index] <= ~hit_way;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if (fill_en) begin
        tag_mem[lru[index]][index]  <= tag;
        data_mem[lru[index]][index] <= bus.sram_rdata;
      end else if (write_hit_en) begin
        data_mem[hit_way][index] <= bus.wdata;
      end
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Directed testbench for cache_controller: SRAM reply modelled with sram_ready on the
// fifth cycle of each access; every expected value is hand-derived.
module tb_cache_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  cache_controller_if bus ();

  cache_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic idle_bus();
    bus.MEM_R_EN   = 1'b0;
    bus.MEM_W_EN   = 1'b0;
    bus.sram_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_bus();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Holds a request until ready=1, recording stalls and which SRAM enables were seen.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] sd, input logic hold,
                            output int stalls, output logic [31:0] got,
                            output logic saw_rd, output logic saw_wr);
    logic done;
    @(negedge clk);
    bus.MEM_R_EN = rd;
    bus.MEM_W_EN = wr;
    bus.address  = addr;
    bus.wdata    = wd;
    stalls = 0; got = 32'd0; saw_rd = 1'b0; saw_wr = 1'b0; done = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      bus.sram_ready = (cyc == 4);
      bus.sram_rdata = sd;
      #1;
      saw_rd = saw_rd | bus.sram_rd_en;
      saw_wr = saw_wr | bus.sram_wr_en;
      if (bus.ready) begin
        got  = bus.rdata;
        done = 1'b1;
      end else begin
        stalls++;
      end
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("[TB] FAIL access_timeout addr=%h: ready never rose, required ready=1", addr);
    end
    @(negedge clk);
    bus.sram_ready = 1'b0;
    if (!hold) idle_bus();
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_bus();
    bus.address = 32'h400; bus.wdata = 32'd0; bus.sram_rdata = 32'd0;
    rst = 1'b0;
    #1;
    vectors++; if (bus.ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready got=%b exp=1", bus.ready); end
    vectors++; if (bus.sram_rd_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rd_en got=%b exp=0", bus.sram_rd_en); end
    vectors++; if (bus.sram_wr_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wr_en got=%b exp=0", bus.sram_wr_en); end
    vectors++; if (bus.rdata !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_rdata got=%h exp=0", bus.rdata); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_read_miss();
    int st; logic [31:0] d; logic r, w;
    run_access(1, 0, 32'h400, 0, 32'hDEADBEEF, 0, st, d, r, w);
    vectors++; if (st !== 4) begin miscompares++; $display("[TB] FAIL miss_stalls got=%0d exp=4", st); end
    vectors++; if (d !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL miss_rdata got=%h exp=deadbeef", d); end
    vectors++; if (r !== 1'b1) begin miscompares++; $display("[TB] FAIL miss_rd_en got=%b exp=1", r); end
    run_access(1, 0, 32'h400, 0, 32'h0BAD0BAD, 0, st, d, r, w);
    vectors++; if (st !== 0) begin miscompares++; $display("[TB] FAIL rehit_stalls got=%0d exp=0", st); end
    vectors++; if (d !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL rehit_rdata got=%h exp=deadbeef", d); end
    vectors++; if (r !== 1'b0) begin miscompares++; $display("[TB] FAIL rehit_rd_en got=%b exp=0", r); end
  endtask

  task automatic test_back_to_back();
    int st; logic [31:0] d; logic r, w;
    run_access(1, 0, 32'h800, 0, 32'h00000800, 1, st, d, r, w);
    #1;
    vectors++; if (bus.ready !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_ready got=%b exp=1", bus.ready); end
    vectors++; if (bus.sram_rd_en !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_rd_en got=%b exp=0", bus.sram_rd_en); end
    vectors++; if (bus.rdata !== 32'h00000800) begin miscompares++; $display("[TB] FAIL b2b_rdata got=%h exp=00000800", bus.rdata); end
    idle_bus();
  endtask

  task automatic test_lru();
    int st; logic [31:0] d; logic r, w;
    do_reset();
    run_access(1, 0, 32'h400, 0, 32'hA0000400, 0, st, d, r, w);
    run_access(1, 0, 32'h500, 0, 32'hB0000500, 0, st, d, r, w);
    run_access(1, 0, 32'h400, 0, 32'h0, 0, st, d, r, w);
    vectors++; if (st !== 0 || d !== 32'hA0000400) begin miscompares++; $display("[TB] FAIL lru_hit400 stalls=%0d data=%h exp 0/a0000400", st, d); end
    run_access(1, 0, 32'h500, 0, 32'h0, 0, st, d, r, w);
    vectors++; if (st !== 0 || d !== 32'hB0000500) begin miscompares++; $display("[TB] FAIL lru_hit500 stalls=%0d data=%h exp 0/b0000500", st, d); end
    run_access(1, 0, 32'h600, 0, 32'hC0000600, 0, st, d, r, w);
    vectors++; if (st !== 4 || d !== 32'hC0000600) begin miscompares++; $display("[TB] FAIL lru_miss600 stalls=%0d data=%h exp 4/c0000600", st, d); end
    run_access(1, 0, 32'h600, 0, 32'h0, 0, st, d, r, w);
    vectors++; if (st !== 0 || d !== 32'hC0000600) begin miscompares++; $display("[TB] FAIL lru_hit600 stalls=%0d data=%h exp 0/c0000600", st, d); end
    run_access(1, 0, 32'h400, 0, 32'hA2000400, 0, st, d, r, w);
    vectors++; if (st !== 4 || d !== 32'hA2000400) begin miscompares++; $display("[TB] FAIL lru_evicted400 stalls=%0d data=%h exp 4/a2000400", st, d); end
  endtask

  task automatic test_write_hit();
    int st; logic [31:0] d; logic r, w;
    run_access(0, 1, 32'h400, 32'h12345678, 32'h0, 0, st, d, r, w);
    vectors++; if (st !== 4) begin miscompares++; $display("[TB] FAIL wrhit_stalls got=%0d exp=4", st); end
    vectors++; if (w !== 1'b1 || r !== 1'b0) begin miscompares++; $display("[TB] FAIL wrhit_enables wr=%b rd=%b exp 1/0", w, r); end
    run_access(1, 0, 32'h400, 0, 32'h0, 0, st, d, r, w);
    vectors++; if (st !== 0 || d !== 32'h12345678) begin miscompares++; $display("[TB] FAIL wrhit_reread stalls=%0d data=%h exp 0/12345678", st, d); end
  endtask

  task automatic test_write_miss();
    int st; logic [31:0] d; logic r, w;
    run_access(0, 1, 32'h700, 32'h77777777, 32'h0, 0, st, d, r, w);
    vectors++; if (st !== 4 || w !== 1'b1 || r !== 1'b0) begin miscompares++; $display("[TB] FAIL wrmiss stalls=%0d wr=%b rd=%b exp 4/1/0", st, w, r); end
    vectors++; if (bus.sram_addr !== 32'h700) begin miscompares++; $display("[TB] FAIL sram_addr got=%h exp=00000700", bus.sram_addr); end
    vectors++; if (bus.sram_wdata !== 32'h77777777) begin miscompares++; $display("[TB] FAIL sram_wdata got=%h exp=77777777", bus.sram_wdata); end
    run_access(1, 0, 32'h700, 0, 32'hD7000700, 0, st, d, r, w);
    vectors++; if (st !== 4 || d !== 32'hD7000700) begin miscompares++; $display("[TB] FAIL no_alloc stalls=%0d data=%h exp 4/d7000700", st, d); end
  endtask

  task automatic test_drop();
    int st; logic [31:0] d; logic r, w;
    @(negedge clk);
    bus.MEM_R_EN = 1'b1; bus.address = 32'h900;
    repeat (2) @(negedge clk);
    idle_bus();
    #1;
    vectors++; if (bus.sram_rd_en !== 1'b0 || bus.ready !== 1'b1) begin miscompares++; $display("[TB] FAIL drop_outputs rd_en=%b ready=%b exp 0/1", bus.sram_rd_en, bus.ready); end
    run_access(1, 0, 32'h900, 0, 32'h99999999, 0, st, d, r, w);
    vectors++; if (st !== 4 || d !== 32'h99999999) begin miscompares++; $display("[TB] FAIL drop_nofill stalls=%0d data=%h exp 4/99999999", st, d); end
  endtask

  task automatic test_reset_mid();
    int st; logic [31:0] d; logic r, w;
    @(negedge clk);
    bus.MEM_R_EN = 1'b1; bus.address = 32'h400;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++; if (bus.sram_rd_en !== 1'b0 || bus.ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rstmid_during rd_en=%b ready=%b exp 0/1", bus.sram_rd_en, bus.ready); end
    @(negedge clk);
    rst = 1'b1;
    idle_bus();
    #1;
    vectors++; if (bus.sram_rd_en !== 1'b0 || bus.ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rstmid_after rd_en=%b ready=%b exp 0/1", bus.sram_rd_en, bus.ready); end
    run_access(1, 0, 32'h400, 0, 32'h44440400, 0, st, d, r, w);
    vectors++; if (st !== 4 || r !== 1'b1) begin miscompares++; $display("[TB] FAIL rstmid_miss stalls=%0d rd=%b exp 4/1", st, r); end
  endtask

  task automatic test_write_priority();
    int st; logic [31:0] d; logic r, w;
    run_access(1, 1, 32'h400, 32'hCAFEF00D, 32'h0, 0, st, d, r, w);
    vectors++; if (w !== 1'b1 || r !== 1'b0) begin miscompares++; $display("[TB] FAIL prio_enables wr=%b rd=%b exp 1/0", w, r); end
    vectors++; if (st !== 4) begin miscompares++; $display("[TB] FAIL prio_stalls got=%0d exp=4", st); end
    run_access(1, 0, 32'h400, 0, 32'h0, 0, st, d, r, w);
    vectors++; if (st !== 0 || d !== 32'hCAFEF00D) begin miscompares++; $display("[TB] FAIL prio_reread stalls=%0d data=%h exp 0/cafef00d", st, d); end
  endtask

  initial begin
    idle_bus();
    bus.address = 32'd0; bus.wdata = 32'd0; bus.sram_rdata = 32'd0;
    test_reset();
    test_read_miss();
    test_back_to_back();
    test_lru();
    test_write_hit();
    test_write_miss();
    test_drop();
    test_reset_mid();
    test_write_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
